usb_rx_frontend: RTL and testbench

USB_RX_FRONTEND -- requirements
Module: usb_rx_frontend

---
 rtl/usb_rx_frontend.sv | 215 +++++++++++++++++++++
 tb/tb_usb_rx_frontend.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_frontend.sv
// USB receive front end: classifies dp/dm line states, NRZI-decodes J/K
// samples, hunts for the KJKJKJKK SYNC, removes stuffed bits and tracks the
// SE0,SE0,J end-of-packet. The serial output stream with its qualifiers
// feeds the downstream PID checker.
module usb_rx_frontend #(
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dp,
    input  logic dm,
    output logic s_out,
    output logic bit_valid,
    output logic start_decode,
    output logic pkt_end,
    output logic rx_err,
    output logic rx_active
);

    // Timeout counter holds 0 .. IDLE_TIMEOUT-1 J samples seen so far.
    localparam int TW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t          state_r;
    logic            prev_j_r;
    logic [2:0]      sync_cnt_r;
    logic [2:0]      ones_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [1:0]      se0_cnt_r;
    logic            first_bit_r;

    logic            s_out_r;
    logic            bit_valid_r;
    logic            start_decode_r;
    logic            pkt_end_r;
    logic            rx_err_r;
    logic            rx_active_r;

    logic            is_jk_s;
    logic            is_j_s;
    logic            is_se0_s;
    logic            is_se1_s;
    logic            dec_bit_s;
    logic            sync_exp_s;

    // Line-state classification and NRZI decode of the current sample.
    always_comb begin
        is_jk_s    = dp ^ dm;
        is_j_s     = dp & ~dm;
        is_se0_s   = ~dp & ~dm;
        is_se1_s   = dp & dm;
        // A J/K sample equal to the previous J/K state decodes as 1.
        dec_bit_s  = (dp == prev_j_r);
        // Last SYNC position expects the trailing KK (a decoded 1).
        sync_exp_s = (sync_cnt_r == 3'd7);
    end

    // Receive FSM with all outputs registered one cycle after the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            prev_j_r       <= 1'b1;
            sync_cnt_r     <= 3'd0;
            ones_cnt_r     <= 3'd0;
            tmo_cnt_r      <= TMO_ZERO;
            se0_cnt_r      <= 2'd0;
            first_bit_r    <= 1'b0;
            s_out_r        <= 1'b0;
            bit_valid_r    <= 1'b0;
            start_decode_r <= 1'b0;
            pkt_end_r      <= 1'b0;
            rx_err_r       <= 1'b0;
            rx_active_r    <= 1'b0;
        end else begin
            bit_valid_r    <= 1'b0;
            start_decode_r <= 1'b0;
            pkt_end_r      <= 1'b0;
            rx_err_r       <= 1'b0;
            rx_active_r    <= 1'b0;

            // NRZI reference only follows J/K samples, never SE0/SE1.
            if (is_jk_s) begin
                prev_j_r <= dp;
            end

            case (state_r)
                ST_IDLE: begin
                    // The first K after idle J decodes as 0 and opens SYNC.
                    if (is_jk_s && !dec_bit_s) begin
                        state_r    <= ST_SYNC;
                        sync_cnt_r <= 3'd1;
                    end
                end

                ST_SYNC: begin
                    if (is_jk_s && (dec_bit_s == sync_exp_s)) begin
                        if (sync_cnt_r == 3'd7) begin
                            // Trailing KK is itself a 1 for the stuffing count.
                            state_r     <= ST_DATA;
                            sync_cnt_r  <= 3'd0;
                            ones_cnt_r  <= 3'd1;
                            first_bit_r <= 1'b1;
                            rx_active_r <= 1'b1;
                        end else begin
                            sync_cnt_r <= sync_cnt_r + 3'd1;
                        end
                    end else begin
                        // Broken SYNC is treated as noise, not an error.
                        state_r    <= ST_IDLE;
                        sync_cnt_r <= 3'd0;
                    end
                end

                ST_DATA: begin
                    if (is_se0_s) begin
                        state_r   <= ST_EOP;
                        se0_cnt_r <= 2'd1;
                    end else if (is_se1_s) begin
                        state_r   <= ST_ERROR;
                        tmo_cnt_r <= TMO_ZERO;
                        se0_cnt_r <= 2'd0;
                        rx_err_r  <= 1'b1;
                    end else if (ones_cnt_r == 3'd6) begin
                        if (dec_bit_s) begin
                            // Seventh consecutive 1 violates bit stuffing.
                            state_r   <= ST_ERROR;
                            tmo_cnt_r <= TMO_ZERO;
                            se0_cnt_r <= 2'd0;
                            rx_err_r  <= 1'b1;
                        end else begin
                            // Stuffed 0: swallow it, stream stays active.
                            ones_cnt_r  <= 3'd0;
                            rx_active_r <= 1'b1;
                        end
                    end else begin
                        s_out_r        <= dec_bit_s;
                        bit_valid_r    <= 1'b1;
                        start_decode_r <= first_bit_r;
                        first_bit_r    <= 1'b0;
                        ones_cnt_r     <= dec_bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
                        rx_active_r    <= 1'b1;
                    end
                end

                ST_EOP: begin
                    if (is_se0_s && (se0_cnt_r == 2'd1)) begin
                        se0_cnt_r <= 2'd2;
                    end else if (is_j_s && (se0_cnt_r == 2'd2)) begin
                        state_r   <= ST_IDLE;
                        se0_cnt_r <= 2'd0;
                        pkt_end_r <= 1'b1;
                    end else begin
                        // Short SE0, over-long SE0, K after SE0s, or SE1.
                        state_r   <= ST_ERROR;
                        tmo_cnt_r <= TMO_ZERO;
                        se0_cnt_r <= 2'd0;
                        rx_err_r  <= 1'b1;
                    end
                end

                ST_ERROR: begin
                    if (is_se0_s) begin
                        se0_cnt_r <= (se0_cnt_r == 2'd2) ? 2'd2 : (se0_cnt_r + 2'd1);
                        tmo_cnt_r <= TMO_ZERO;
                    end else if (is_j_s) begin
                        if (se0_cnt_r == 2'd2) begin
                            // Proper EOP seen: tell the PID checker to clear.
                            state_r   <= ST_IDLE;
                            se0_cnt_r <= 2'd0;
                            tmo_cnt_r <= TMO_ZERO;
                            pkt_end_r <= 1'b1;
                        end else if (tmo_cnt_r == TMO_LAST) begin
                            // Long idle J: silently resynchronise.
                            state_r   <= ST_IDLE;
                            se0_cnt_r <= 2'd0;
                            tmo_cnt_r <= TMO_ZERO;
                        end else begin
                            se0_cnt_r <= 2'd0;
                            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                        end
                    end else begin
                        se0_cnt_r <= 2'd0;
                        tmo_cnt_r <= TMO_ZERO;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    sync_cnt_r <= 3'd0;
                    ones_cnt_r <= 3'd0;
                    tmo_cnt_r  <= TMO_ZERO;
                    se0_cnt_r  <= 2'd0;
                end
            endcase
        end
    end

    assign s_out        = s_out_r;
    assign bit_valid    = bit_valid_r;
    assign start_decode = start_decode_r;
    assign pkt_end      = pkt_end_r;
    assign rx_err       = rx_err_r;
    assign rx_active    = rx_active_r;

endmodule

// File: tb/tb_usb_rx_frontend.sv
// Bench for usb_rx_frontend: a table-driven ACK packet plus hand-written
// sequences for stuffing, stuffing errors, broken SYNC, bad EOP, SE1 and
// mid-packet reset. Every driven sample pushes its expected registered
// outputs into a queue; a negedge monitor pops and compares them.
module tb_usb_rx_frontend;

    localparam logic [1:0] LJ  = 2'b10;
    localparam logic [1:0] LK  = 2'b01;
    localparam logic [1:0] LS0 = 2'b00;
    localparam logic [1:0] LS1 = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dp    = 1'b1;
    logic dm    = 1'b0;
    logic s_out, bit_valid, start_decode, pkt_end, rx_err, rx_active;

    usb_rx_frontend #(.IDLE_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dp           (dp),
        .dm           (dm),
        .s_out        (s_out),
        .bit_valid    (bit_valid),
        .start_decode (start_decode),
        .pkt_end      (pkt_end),
        .rx_err       (rx_err),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    // f = {bit_valid, s_out, start_decode, pkt_end, rx_err, rx_active}
    typedef struct packed {
        logic [1:0] ln;
        logic [5:0] f;
    } vec_t;

    typedef struct {
        string      tag;
        int         idx;
        logic [5:0] exp;   // {s_out, bit_valid, start, end, err, active}
    } sb_t;

    sb_t        sb_q[$];
    int         errors    = 0;
    int         checks    = 0;
    int         step_no   = 0;
    string      cur_tag   = "reset";
    logic       tx_line   = 1'b1;
    logic       last_sout = 1'b0;
    int         mon_bits  = 0;
    int         last_bits = 0;
    int         pkt_ends  = 0;
    logic [7:0] mon_pid   = 8'd0;
    logic [7:0] last_pid  = 8'd0;
    vec_t       ack_tab [23];

    // Scoreboard: compare outputs against the oldest expectation, and
    // collect the payload of each packet for the PID checks.
    always @(negedge clk) begin
        sb_t        e;
        logic [5:0] got;
        if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            got = {s_out, bit_valid, start_decode, pkt_end, rx_err, rx_active};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d: got s/v/st/end/err/act=%b required %b",
                         e.tag, e.idx, got, e.exp);
            end
        end
        if (start_decode) begin
            mon_bits = 1;
            mon_pid  = {s_out, 7'd0};
        end else if (bit_valid) begin
            mon_bits++;
            mon_pid = {s_out, mon_pid[7:1]};
        end
        if (pkt_end) begin
            last_bits = mon_bits;
            last_pid  = mon_pid;
            pkt_ends++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] ln, input logic [5:0] f);
        return {ln, f};
    endfunction

    // Drive one line sample and queue the outputs it must produce.
    task automatic step(input logic r, input logic [1:0] ln, input logic [5:0] f);
        sb_t e;
        @(negedge clk);
        #1;
        rst_n = r;
        {dp, dm} = ln;
        if (ln == LJ) tx_line = 1'b1;
        if (ln == LK) tx_line = 1'b0;
        if (!r) last_sout = 1'b0;
        else if (f[5]) last_sout = f[4];
        e.tag = cur_tag;
        e.idx = step_no;
        e.exp = r ? {last_sout, f[5], f[3], f[2], f[1], f[0]} : 6'd0;
        sb_q.push_back(e);
        step_no++;
    endtask

    // NRZI-encode one bit: 1 keeps the line, 0 toggles it.
    task automatic send_bit(input logic b, input logic v, input logic st,
                            input logic er, input logic act);
        logic nl;
        nl = b ? tx_line : ~tx_line;
        step(1'b1, nl ? LJ : LK, {v, b, st, 1'b0, er, act});
    endtask

    task automatic send_j(input int n);
        for (int i = 0; i < n; i++) step(1'b1, LJ, 6'b000000);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // SYNC, eight unstuffed payload bits (LSB first), then SE0,SE0,J.
    task automatic send_packet(input logic [7:0] bits);
        send_sync();
        for (int i = 0; i < 8; i++) send_bit(bits[i], 1'b1, (i == 0), 1'b0, 1'b1);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LJ,  6'b000100);
        step(1'b1, LJ,  6'b000000);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    initial begin
        int ends0;

        // ACK packet: idle J, KJKJKJKK, PID 0,1,0,0,1,0,1,1, SE0,SE0,J.
        ack_tab[0]  = mk(LJ,  6'b000000);
        ack_tab[1]  = mk(LJ,  6'b000000);
        ack_tab[2]  = mk(LJ,  6'b000000);
        ack_tab[3]  = mk(LK,  6'b000000);
        ack_tab[4]  = mk(LJ,  6'b000000);
        ack_tab[5]  = mk(LK,  6'b000000);
        ack_tab[6]  = mk(LJ,  6'b000000);
        ack_tab[7]  = mk(LK,  6'b000000);
        ack_tab[8]  = mk(LJ,  6'b000000);
        ack_tab[9]  = mk(LK,  6'b000000);
        ack_tab[10] = mk(LK,  6'b000001);
        ack_tab[11] = mk(LJ,  6'b101001);
        ack_tab[12] = mk(LJ,  6'b110001);
        ack_tab[13] = mk(LK,  6'b100001);
        ack_tab[14] = mk(LJ,  6'b100001);
        ack_tab[15] = mk(LJ,  6'b110001);
        ack_tab[16] = mk(LK,  6'b100001);
        ack_tab[17] = mk(LK,  6'b110001);
        ack_tab[18] = mk(LK,  6'b110001);
        ack_tab[19] = mk(LS0, 6'b000000);
        ack_tab[20] = mk(LS0, 6'b000000);
        ack_tab[21] = mk(LJ,  6'b000100);
        ack_tab[22] = mk(LJ,  6'b000000);

        cur_tag = "reset";
        step(1'b0, LJ, 6'b000000);
        step(1'b0, LJ, 6'b000000);

        cur_tag = "ack";
        ends0 = pkt_ends;
        for (int i = 0; i < 23; i++) step(1'b1, ack_tab[i].ln, ack_tab[i].f);
        drain();
        check("ack pkt_end count", pkt_ends - ends0, 1);
        check("ack bit_valid cycles", last_bits, 8);
        check("ack pid", int'(last_pid), 8'hD2);
        check("ack PID_valid", int'(last_pid[3:0] == ~last_pid[7:4]), 1);

        // Five data 1s after SYNC's trailing 1, stuffed 0, then 1,1,0.
        cur_tag = "stuff";
        send_j(2);
        send_sync();
        send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LJ,  6'b000100);
        drain();
        check("stuff bit_valid cycles", last_bits, 8);
        check("stuff payload", int'(last_pid), 8'h7F);

        // Seventh consecutive 1 -> rx_err; 7 J keep ERROR, 8 J leave it.
        cur_tag = "stuff_err";
        ends0 = pkt_ends;
        send_j(2);
        send_sync();
        send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_j(7);
        cur_tag = "still_error";
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_j(8);
        drain();
        check("timeout no pkt_end", pkt_ends - ends0, 0);

        // Broken SYNC KJKJJ is ignored; the next SYNC is accepted.
        cur_tag = "bad_sync";
        step(1'b1, LK, 6'b000000);
        step(1'b1, LJ, 6'b000000);
        step(1'b1, LK, 6'b000000);
        step(1'b1, LJ, 6'b000000);
        step(1'b1, LJ, 6'b000000);
        send_j(1);
        cur_tag = "after_bad_sync";
        send_packet(8'hA5);
        drain();
        check("after bad sync payload", int'(last_pid), 8'hA5);

        // Single SE0 then K -> rx_err, then SE0,SE0,J -> pkt_end.
        cur_tag = "short_eop";
        send_j(1);
        send_sync();
        send_bit(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LK,  6'b000010);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LS0, 6'b000000);
        step(1'b1, LJ,  6'b000100);
        step(1'b1, LJ,  6'b000000);

        // SE1 in DATA -> rx_err, then timeout back to IDLE.
        cur_tag = "se1";
        send_sync();
        send_bit(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, LS1, 6'b000010);
        send_j(8);

        // Reset asserted in the PID bits, then a full ACK packet.
        cur_tag = "mid_reset";
        send_j(1);
        send_sync();
        send_bit(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, LJ, 6'b000000);
        step(1'b0, LJ, 6'b000000);
        step(1'b1, LJ, 6'b000000);
        cur_tag = "after_reset";
        ends0 = pkt_ends;
        send_packet(8'hD2);
        drain();
        check("after reset pkt_end count", pkt_ends - ends0, 1);
        check("after reset bit_valid cycles", last_bits, 8);
        check("after reset pid", int'(last_pid), 8'hD2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
